// File: rtl/scoreboard_pkg.sv
// Shared scoreboard-chain definitions: emulator FSM encoding, command
// directions and the press/gap timing defaults shared with the processor.
package scoreboard_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic CMD_UP   = 1'b0;
    localparam logic CMD_DOWN = 1'b1;

    localparam int DEF_SHORT_MS = 50;
    localparam int DEF_LONG_MS  = 1000;
    localparam int DEF_GAP_MS   = 100;

endpackage

// File: rtl/pb_emu_timer.sv
// Loadable down-counter with zero flag for the pushbutton emulator.
// Ports: i_clk, i_rst_n, i_load/i_load_val, i_dec -> o_zero.
module pb_emu_timer #(
    parameter int CNT_BW = 11
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [CNT_BW-1:0] i_load_val,
    input  logic              i_dec,
    output logic              o_zero
);

    logic [CNT_BW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pushbutton_emulator.sv
// Pushbutton emulator: up/down commands -> short/long press waveform.
// Ports: clk_1khz_i, rst_n_i, cmd_valid_i, cmd_down_i -> cmd_ready_o,
//   pushbutton_o, busy_o, sent_cnt_o. Build macro PB_EMU_ACTIVE_LOW_EN
//   inverts pushbutton_o for buttons wired to ground.
module pushbutton_emulator
    import scoreboard_pkg::*;
#(
    parameter int SHORT_MS = DEF_SHORT_MS,
    parameter int LONG_MS  = DEF_LONG_MS,
    parameter int GAP_MS   = DEF_GAP_MS,
    parameter int CNT_BW   = 11
) (
    input  logic       clk_1khz_i,
    input  logic       rst_n_i,
    input  logic       cmd_valid_i,
    input  logic       cmd_down_i,
    output logic       cmd_ready_o,
    output logic       pushbutton_o,
    output logic       busy_o,
    output logic [7:0] sent_cnt_o
);

    if (((2 ** CNT_BW) <= SHORT_MS) ||
        ((2 ** CNT_BW) <= LONG_MS) ||
        ((2 ** CNT_BW) <= GAP_MS)) begin : g_cnt_bw_chk
        $error("CNT_BW too small for press/gap durations");
    end

`ifdef PB_EMU_ACTIVE_LOW_EN
    localparam logic PB_INV = 1'b1;
`else
    localparam logic PB_INV = 1'b0;
`endif

    localparam logic [CNT_BW-1:0] LD_SHORT = CNT_BW'(SHORT_MS - 1);
    localparam logic [CNT_BW-1:0] LD_LONG  = CNT_BW'(LONG_MS - 1);
    localparam logic [CNT_BW-1:0] LD_GAP   = CNT_BW'(GAP_MS - 1);

    function automatic logic [CNT_BW-1:0] press_ld(input logic dn);
        return (dn == CMD_DOWN) ? LD_LONG : LD_SHORT;
    endfunction

    logic [1:0]        r_state;
    logic              r_pend_full;
    logic              r_pend_dir;
    logic              r_pressed;
    logic              r_busy;
    logic [7:0]        r_sent;

    logic [1:0]        w_next;
    logic              w_accept;
    logic              w_load;
    logic [CNT_BW-1:0] w_load_val;
    logic              w_dec;
    logic              w_zero;
    logic              w_pend_set;
    logic              w_pend_clr;
    logic              w_sent_inc;

    assign w_accept = cmd_valid_i && !r_pend_full;

    pb_emu_timer #(
        .CNT_BW(CNT_BW)
    ) u_timer (
        .i_clk      (clk_1khz_i),
        .i_rst_n    (rst_n_i),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        w_pend_set = 1'b0;
        w_pend_clr = 1'b0;
        w_sent_inc = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load     = 1'b1;
                    w_load_val = press_ld(cmd_down_i);
                    w_next     = ST_PRESS;
                end
            end
            ST_PRESS: begin
                w_pend_set = w_accept;
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = LD_GAP;
                    w_next     = ST_GAP;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_zero) begin
                    w_sent_inc = 1'b1;
                    // Pending wins; ready is low then, so no accept can
                    // collide. An accept on the last gap cycle with an
                    // empty buffer starts directly, keeping the gap exact.
                    if (r_pend_full) begin
                        w_pend_clr = 1'b1;
                        w_load     = 1'b1;
                        w_load_val = press_ld(r_pend_dir);
                        w_next     = ST_PRESS;
                    end else if (w_accept) begin
                        w_load     = 1'b1;
                        w_load_val = press_ld(cmd_down_i);
                        w_next     = ST_PRESS;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end else begin
                    w_dec      = 1'b1;
                    w_pend_set = w_accept;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_1khz_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_pend_full <= 1'b0;
            r_pend_dir  <= CMD_UP;
            r_pressed   <= 1'b0;
            r_busy      <= 1'b0;
            r_sent      <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_pend_set) begin
                r_pend_full <= 1'b1;
                r_pend_dir  <= cmd_down_i;
            end else if (w_pend_clr) begin
                r_pend_full <= 1'b0;
            end
            // Outputs follow the state by one edge: the pin rises on the
            // edge after the accept edge.
            r_pressed <= (r_state == ST_PRESS);
            r_busy    <= (r_state != ST_IDLE) || r_pend_full;
            if (w_sent_inc) begin
                r_sent <= r_sent + 8'd1;
            end
        end
    end

    assign cmd_ready_o  = !r_pend_full;
    assign pushbutton_o = r_pressed ^ PB_INV;
    assign busy_o       = r_busy;
    assign sent_cnt_o   = r_sent;

endmodule

// File: tb/tb_pushbutton_emulator.sv
// Scoreboard bench for pushbutton_emulator: expected presses are queued
// at accept time and checked by a pin monitor.
module tb_pushbutton_emulator;

`ifdef PB_EMU_ACTIVE_LOW_EN
    localparam logic PRESSED = 1'b0;
`else
    localparam logic PRESSED = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic       down = 1'b0;
    logic       ready;
    logic       pb;
    logic       busy;
    logic [7:0] sent;

    pushbutton_emulator dut (
        .clk_1khz_i   (clk),
        .rst_n_i      (rst_n),
        .cmd_valid_i  (valid),
        .cmd_down_i   (down),
        .cmd_ready_o  (ready),
        .pushbutton_o (pb),
        .busy_o       (busy),
        .sent_cnt_o   (sent)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int high;
        int rise_at;
        int gap;
    } exp_t;

    exp_t q[$];
    int   chk = 0;
    int   err = 0;

    task automatic check(input string nm, input int act, input int exp);
        chk++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: measures every press on the pin against the queue.
    logic mon_prev = 1'b0;
    int   mon_rise = 0;
    int   mon_fall = -1;

    always @(negedge clk) begin
        logic on;
        exp_t e;
        if (!rst_n) begin
            mon_prev = 1'b0;
            mon_fall = -1;
        end else begin
            on = (pb === PRESSED);
            if (on && !mon_prev) begin
                mon_rise = cyc;
                if (q.size() == 0) begin
                    check("unexpected_press", 1, 0);
                end else begin
                    if (q[0].rise_at >= 0)
                        check("rise_latency", cyc, q[0].rise_at);
                    if (q[0].gap >= 0 && mon_fall >= 0)
                        check("gap_len", cyc - mon_fall, q[0].gap);
                end
            end else if (!on && mon_prev) begin
                mon_fall = cyc;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("high_len", cyc - mon_rise, e.high);
                end
            end
            mon_prev = on;
        end
    end

    task automatic send(input logic dn, input int hi,
                        input bit from_idle, output int acc);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        valid = 1'b1;
        down  = dn;
        while (!ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            check("accept_timeout", 0, 1);
            valid = 1'b0;
            acc = -1;
        end else begin
            acc = cyc + 1;
            e.high    = hi;
            e.rise_at = from_idle ? acc + 1 : -1;
            e.gap     = from_idle ? -1 : 100;
            q.push_back(e);
            @(posedge clk);
            #1;
            valid = 1'b0;
            down  = 1'b0;
        end
    endtask

    task automatic wait_idle(output int fe);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 0, 1);
        fe = cyc;
    endtask

    initial begin
        int a;
        int a2;
        int a3;
        int fe;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_pb", pb, !PRESSED);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_sent", sent, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single up
        send(1'b0, 50, 1'b1, a);
        wait_idle(fe);
        check("busy_fall_edge", fe, a + 151);
        check("sent_after_up", sent, 1);
        check("q_empty_1", q.size(), 0);

        // single down
        send(1'b1, 1000, 1'b1, a);
        wait_idle(fe);
        check("sent_after_down", sent, 2);
        check("q_empty_2", q.size(), 0);

        // up, down, up back-to-back
        send(1'b0, 50, 1'b1, a);
        send(1'b1, 1000, 1'b0, a2);
        check("second_accept", a2, a + 1);
        @(negedge clk);
        check("ready_low_pending", ready, 0);
        check("busy_pending", busy, 1);
        send(1'b0, 50, 1'b0, a3);
        check("third_accept", a3, a + 151);
        wait_idle(fe);
        check("sent_after_burst", sent, 5);
        check("q_empty_3", q.size(), 0);

        // reset 20 cycles into a long press, one command pending
        send(1'b1, 1000, 1'b1, a);
        send(1'b0, 50, 1'b0, a2);
        repeat (20) @(negedge clk);
        check("pressed_before_rst", pb, PRESSED);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_pb_drop", pb, !PRESSED);
        check("rst_sent_clear", sent, 0);
        check("rst_ready_mid", ready, 1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", ready, 1);
        check("busy_after_rst", busy, 0);
        repeat (200) @(negedge clk);
        check("pending_lost_pb", pb, !PRESSED);
        check("pending_lost_sent", sent, 0);

        // 256 up commands wrap the sent counter
        for (int i = 0; i < 256; i++) begin
            send(1'b0, 50, (i == 0), a);
            if (i == 254) check("sent_before_last", sent, 253);
        end
        wait_idle(fe);
        check("sent_wrap", sent, 0);
        check("q_empty_4", q.size(), 0);
        check("idle_pb_level", pb, !PRESSED);

        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
